// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between an instruction-fetch port and a load/store port.
// Optional build macro ARB_RR_EN selects round-robin arbitration instead of data priority.
module mem_port_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            f_req,
  input  logic [AW-1:0]   f_addr,
  output logic            f_gnt,
  output logic            f_rvalid,
  output logic [DW-1:0]   f_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_en,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_RD_F = 2'd1,
    PEND_RD_D = 2'd2
  } pend_e;

  pend_e           pend_r, pend_nxt_s;
  logic            f_prio_s;
  logic            f_gnt_s, d_gnt_s;
  logic [AW-1:0]   addr_hold_r;
  logic [DW-1:0]   wdata_hold_r;
  logic [DW-1:0]   f_rdata_hold_r, d_rdata_hold_r;
  logic            f_rvalid_r, d_rvalid_r;

`ifdef ARB_RR_EN
  logic last_f_r;

  assign f_prio_s = ~last_f_r;

  // Remembers which port won the most recent grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_f_r <= 1'b0;
    end else if (f_gnt_s) begin
      last_f_r <= 1'b1;
    end else if (d_gnt_s) begin
      last_f_r <= 1'b0;
    end else begin
      last_f_r <= last_f_r;
    end
  end
`else
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] starve_cnt_r;

  assign f_prio_s = (starve_cnt_r == CW'(MAX_WAIT));

  // Counts cycles a waiting fetch has been denied, saturating at MAX_WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r <= {CW{1'b0}};
    end else if (!f_req || f_gnt_s) begin
      starve_cnt_r <= {CW{1'b0}};
    end else if (starve_cnt_r != CW'(MAX_WAIT)) begin
      starve_cnt_r <= starve_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`endif

  // Grant selection; nothing is granted while reset is asserted
  always_comb begin
    f_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (!rst) begin
      f_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (f_req && d_req) begin
      f_gnt_s = f_prio_s;
      d_gnt_s = ~f_prio_s;
    end else begin
      f_gnt_s = f_req;
      d_gnt_s = d_req;
    end
  end

  assign f_gnt = f_gnt_s;
  assign d_gnt = d_gnt_s;

  // SRAM request mux; address and write data hold when idle
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_be    = {BW{1'b0}};
    m_addr  = addr_hold_r;
    m_wdata = wdata_hold_r;
    if (f_gnt_s) begin
      m_en   = 1'b1;
      m_be   = {BW{1'b1}};
      m_addr = f_addr;
    end else if (d_gnt_s) begin
      m_en    = 1'b1;
      m_we    = d_we;
      m_be    = d_we ? d_be : {BW{1'b1}};
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else begin
      m_en = 1'b0;
    end
  end

  // Captures the last driven SRAM address and write data for idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_hold_r  <= {AW{1'b0}};
      wdata_hold_r <= {DW{1'b0}};
    end else begin
      addr_hold_r  <= m_addr;
      wdata_hold_r <= m_wdata;
    end
  end

  // Next pending read: decided purely by this cycle's grant
  always_comb begin
    pend_nxt_s = PEND_NONE;
    case (pend_r)
      PEND_NONE, PEND_RD_F, PEND_RD_D: begin
        if (f_gnt_s) begin
          pend_nxt_s = PEND_RD_F;
        end else if (d_gnt_s && !d_we) begin
          pend_nxt_s = PEND_RD_D;
        end else begin
          pend_nxt_s = PEND_NONE;
        end
      end
      default: pend_nxt_s = PEND_NONE;
    endcase
  end

  // Pending-read state and the per-port valid flags derived from it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r     <= PEND_NONE;
      f_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
    end else begin
      pend_r     <= pend_nxt_s;
      f_rvalid_r <= (pend_nxt_s == PEND_RD_F);
      d_rvalid_r <= (pend_nxt_s == PEND_RD_D);
    end
  end

  // Holds the last returned word of each port between responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_rdata_hold_r <= {DW{1'b0}};
      d_rdata_hold_r <= {DW{1'b0}};
    end else begin
      f_rdata_hold_r <= f_rvalid_r ? m_rdata : f_rdata_hold_r;
      d_rdata_hold_r <= d_rvalid_r ? m_rdata : d_rdata_hold_r;
    end
  end

  // The SRAM output register supplies the word in the response cycle itself
  assign f_rvalid = f_rvalid_r;
  assign d_rvalid = d_rvalid_r;
  assign f_rdata  = f_rvalid_r ? m_rdata : f_rdata_hold_r;
  assign d_rdata  = d_rvalid_r ? m_rdata : d_rdata_hold_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte-enabled SRAM.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_gnt, f_rvalid;
  logic [11:0] f_addr;
  logic [31:0] f_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [11:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        m_en, m_we;
  logic [3:0]  m_be;
  logic [11:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [0:4095];

  int checks = 0;
  int fails  = 0;

  mem_port_arbiter #(.AW(12), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (m_en && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
    end else if (m_en) begin
      m_rdata <= mem[m_addr];
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    #1;
    checks++; if (f_gnt !== 1'b0) begin fails++; $display("FAIL reset_f_gnt got %b want 0", f_gnt); end
    checks++; if (d_gnt !== 1'b0) begin fails++; $display("FAIL reset_d_gnt got %b want 0", d_gnt); end
    checks++; if (m_en !== 1'b0) begin fails++; $display("FAIL reset_m_en got %b want 0", m_en); end
    checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %b%b want 00", f_rvalid, d_rvalid); end
    checks++; if (f_rdata !== 32'h0 || d_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h %h want 0", f_rdata, d_rdata); end
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_lone_fetch;
    @(negedge clk);
    f_req = 1'b1; f_addr = 12'h010; d_req = 1'b0;
    #1;
    checks++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin fails++; $display("FAIL fetch_gnt got f=%b d=%b want f=1 d=0", f_gnt, d_gnt); end
    checks++; if (m_en !== 1'b1 || m_we !== 1'b0 || m_be !== 4'hF || m_addr !== 12'h010) begin
      fails++; $display("FAIL fetch_mport got en=%b we=%b be=%h a=%h want 1 0 f 010", m_en, m_we, m_be, m_addr); end
    @(negedge clk);
    f_req = 1'b0;
    #1;
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h0000006F) begin fails++; $display("FAIL fetch_resp got v=%b d=%h want 1 0000006f", f_rvalid, f_rdata); end
    checks++; if (d_rvalid !== 1'b0) begin fails++; $display("FAIL fetch_d_rvalid got %b want 0", d_rvalid); end
    checks++; if (m_en !== 1'b0 || m_be !== 4'h0 || m_addr !== 12'h010) begin
      fails++; $display("FAIL idle_mport got en=%b be=%h a=%h want 0 0 010", m_en, m_be, m_addr); end
    @(negedge clk);
    #1;
    checks++; if (f_rvalid !== 1'b0) begin fails++; $display("FAIL fetch_rvalid_drop got %b want 0", f_rvalid); end
  endtask

  task automatic test_contention;
    logic exp_f, prev_f;
    prev_f = 1'b0;
    f_addr = 12'h010; d_addr = 12'h004; d_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      f_req = 1'b1; d_req = 1'b1;
      #1;
`ifdef ARB_RR_EN
      exp_f = (i % 2 == 1);
`else
      exp_f = (i % 5 == 4);
`endif
      checks++; if (f_gnt !== exp_f || d_gnt !== !exp_f) begin
        fails++; $display("FAIL contention_gnt cycle %0d got f=%b d=%b want f=%b d=%b", i, f_gnt, d_gnt, exp_f, !exp_f); end
      if (i > 0) begin
        checks++; if (f_rvalid !== prev_f || d_rvalid !== !prev_f) begin
          fails++; $display("FAIL contention_rvalid cycle %0d got f=%b d=%b want f=%b d=%b", i, f_rvalid, d_rvalid, prev_f, !prev_f); end
      end
      prev_f = exp_f;
    end
    @(negedge clk);
    f_req = 1'b0; d_req = 1'b0;
    #1;
    checks++; if (f_rvalid !== prev_f || d_rdata !== 32'hCAFE0004) begin
      fails++; $display("FAIL contention_last got f_rvalid=%b d_rdata=%h want %b cafe0004", f_rvalid, d_rdata, prev_f); end
  endtask

  task automatic test_byte_write;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 12'h020; d_wdata = 32'h0000AB00;
    #1;
    checks++; if (d_gnt !== 1'b1 || m_we !== 1'b1 || m_be !== 4'b0010 || m_wdata !== 32'h0000AB00) begin
      fails++; $display("FAIL write_mport got gnt=%b we=%b be=%b wd=%h want 1 1 0010 0000ab00", d_gnt, m_we, m_be, m_wdata); end
    @(negedge clk);
    d_we = 1'b0;
    #1;
    checks++; if (d_rvalid !== 1'b0) begin fails++; $display("FAIL write_no_rvalid got %b want 0", d_rvalid); end
    checks++; if (d_gnt !== 1'b1 || m_be !== 4'hF || m_we !== 1'b0) begin
      fails++; $display("FAIL read_after_write_mport got gnt=%b be=%h we=%b want 1 f 0", d_gnt, m_be, m_we); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1111AB11) begin
      fails++; $display("FAIL byte_merge got v=%b d=%h want 1 1111ab11", d_rvalid, d_rdata); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    f_req = 1'b1; f_addr = 12'h000;
    #1;
    checks++; if (f_gnt !== 1'b1) begin fails++; $display("FAIL b2b_f_gnt got %b want 1", f_gnt); end
    @(negedge clk);
    f_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 12'h004;
    #1;
    checks++; if (d_gnt !== 1'b1 || m_addr !== 12'h004) begin fails++; $display("FAIL b2b_d_gnt got %b a=%h want 1 004", d_gnt, m_addr); end
    checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL b2b_f_resp got v=%b d=%h want 1 deadbeef", f_rvalid, f_rdata); end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE0004 || f_rvalid !== 1'b0) begin
      fails++; $display("FAIL b2b_d_resp got v=%b d=%h fv=%b want 1 cafe0004 0", d_rvalid, d_rdata, f_rvalid); end
    checks++; if (f_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_f_hold got %h want deadbeef", f_rdata); end
  endtask

  task automatic test_reset_mid_read;
    @(negedge clk);
    f_req = 1'b1; f_addr = 12'h000;
    #1;
    checks++; if (f_gnt !== 1'b1) begin fails++; $display("FAIL midrst_gnt got %b want 1", f_gnt); end
    @(posedge clk);
    #1;
    rst = 1'b0; f_req = 1'b0;
    #1;
    checks++; if (f_rvalid !== 1'b0 || f_rdata !== 32'h0) begin
      fails++; $display("FAIL midrst_discard got v=%b d=%h want 0 0", f_rvalid, f_rdata); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (f_rvalid !== 1'b0) begin fails++; $display("FAIL midrst_no_late_resp got %b want 0", f_rvalid); end
    test_lone_fetch();
  endtask

  initial begin
    pl_en = 1'b0; pl_addr = 12'h0; pl_data = 32'h0;
    f_addr = 12'h0; d_be = 4'h0; d_addr = 12'h0; d_wdata = 32'h0; d_we = 1'b0;
    test_reset();
    rst = 1'b0;
    preload(12'h010, 32'h0000006F);
    preload(12'h020, 32'h11111111);
    preload(12'h000, 32'hDEADBEEF);
    preload(12'h004, 32'hCAFE0004);
    @(negedge clk);
    rst = 1'b1;
    test_lone_fetch();
    test_contention();
    test_byte_write();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
